// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences FETCH/DECODE/EXEC/MEM/WB,
// produces the datapath strobes and the 4-bit ALUOp class, stalls on waitrequest, halts on bad opcodes.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] FuncCode,
  input  logic       waitrequest,
  output logic [3:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    C_RTYPE,
    C_JR,
    C_IMM,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JUMP,
    C_BAD
  } iclass_e;

  state_e     state_q;
  iclass_e    iclass;
  logic [3:0] exec_aluop;

  // Instruction class and the ALU operation class used in EXEC.
  always_comb begin
    iclass     = C_BAD;
    exec_aluop = 4'b0000;
    case (Opcode)
      6'b000000: begin
        if (FuncCode == 6'b001000) begin
          iclass = C_JR;
        end else begin
          iclass     = C_RTYPE;
          exec_aluop = 4'b0010;
        end
      end
      6'b001001: begin iclass = C_IMM;    exec_aluop = 4'b0011; end
      6'b001010: begin iclass = C_IMM;    exec_aluop = 4'b0111; end
      6'b001100: begin iclass = C_IMM;    exec_aluop = 4'b0100; end
      6'b001101: begin iclass = C_IMM;    exec_aluop = 4'b0101; end
      6'b001110: begin iclass = C_IMM;    exec_aluop = 4'b0110; end
      6'b100011: begin iclass = C_LOAD;   exec_aluop = 4'b0000; end
      6'b101011: begin iclass = C_STORE;  exec_aluop = 4'b0000; end
      6'b000100: begin iclass = C_BRANCH; exec_aluop = 4'b0001; end
      6'b000101: begin iclass = C_BRANCH; exec_aluop = 4'b1000; end
      6'b000110: begin iclass = C_BRANCH; exec_aluop = 4'b1010; end
      6'b000111: begin iclass = C_BRANCH; exec_aluop = 4'b1001; end
      6'b000001: begin iclass = C_BRANCH; exec_aluop = 4'b1011; end
      6'b000010: begin iclass = C_JUMP;   exec_aluop = 4'b0000; end
      default:   begin iclass = C_BAD;    exec_aluop = 4'b0000; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_q <= S_FETCH;
        S_FETCH:  if (!waitrequest) state_q <= S_DECODE;
        S_DECODE: state_q <= (iclass == C_BAD) ? S_HALT : S_EXEC;
        S_EXEC: begin
          case (iclass)
            C_RTYPE, C_IMM:           state_q <= S_WB;
            C_LOAD, C_STORE:          state_q <= S_MEM;
            C_JR, C_BRANCH, C_JUMP:   state_q <= S_FETCH;
            default:                  state_q <= S_HALT;
          endcase
        end
        S_MEM: begin
          if (!waitrequest) begin
            if (iclass == C_LOAD)       state_q <= S_WB;
            else if (iclass == C_STORE) state_q <= S_FETCH;
            else                        state_q <= S_HALT;
          end
        end
        S_WB:     state_q <= S_FETCH;
        S_HALT:   state_q <= S_HALT;
        default:  state_q <= S_HALT;
      endcase
    end
  end

  // Outputs follow the state register; only the FETCH completion strobes look at waitrequest,
  // so IR and PC load in the same cycle the memory returns data.
  always_comb begin
    ALUOp       = 4'b0000;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = !waitrequest;
        PCWrite = !waitrequest;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
      end
      S_EXEC: begin
        case (iclass)
          C_RTYPE: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b00;
            ALUOp   = exec_aluop;
          end
          C_IMM, C_LOAD, C_STORE: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUOp   = exec_aluop;
          end
          C_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = 2'b00;
            ALUOp       = exec_aluop;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
          end
          C_JR: begin
            PCWrite  = 1'b1;
            PCSource = 2'b11;
          end
          C_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        IorD     = 1'b1;
        MemRead  = (iclass == C_LOAD);
        MemWrite = (iclass == C_STORE);
      end
      S_WB: begin
        RegWrite = (iclass == C_RTYPE) || (iclass == C_IMM) || (iclass == C_LOAD);
        RegDst   = (iclass == C_RTYPE);
        MemtoReg = (iclass == C_LOAD);
      end
      default: ;
    endcase
  end

  assign halted = (state_q == S_HALT);
  assign state  = state_q;

endmodule
